// File: rtl/road_pkg.sv
// Shared types for the road scroll engine: speed codes,
// race FSM states and the speed-code to target-velocity map.
package road_pkg;

  localparam logic [1:0] SPD_STOP = 2'd0;
  localparam logic [1:0] SPD_SLOW = 2'd1;
  localparam logic [1:0] SPD_FAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } road_state_t;

  // Code 3 is not a legal speed and falls back to stop.
  function automatic logic [2:0] speed_target(
    input logic [1:0] spd,
    input logic [2:0] slow,
    input logic [2:0] fast
  );
    logic [2:0] t;
    t = 3'd0;
    unique case (1'b1)
      spd == SPD_STOP: t = 3'd0;
      spd == SPD_SLOW: t = slow;
      spd == SPD_FAST: t = fast;
      default:         t = 3'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/velocity_ramp.sv
// Player velocity register: steps one pixel/frame toward
// the target on each enable pulse, with synchronous clear.
module velocity_ramp (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [2:0] target,
  output logic [2:0] velocity
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      velocity <= 3'd0;
    end else if (enable) begin
      if (velocity < target) begin
        velocity <= velocity + 3'd1;
      end else if (velocity > target) begin
        velocity <= velocity - 3'd1;
      end
    end
  end

endmodule

// File: rtl/road_scroll_engine.sv
// Per-frame road scroll, distance and race FSM.
// Define ROAD_FUEL_EN to build the fuel burn/refuel logic.
module road_scroll_engine
  import road_pkg::*;
#(
  parameter int ROAD_HEIGHT = 480,
  parameter int SLOW_STEP   = 2,
  parameter int FAST_STEP   = 5,
  parameter int DIST_DIV    = 16,
  parameter int RACE_LEN    = 2000,
  parameter int FUEL_INIT   = 100
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        one_sec,
  input  logic [1:0]  speed,
  input  logic        start,
  input  logic        refuel,
  output logic [9:0]  scroll_offset,
  output logic [2:0]  velocity,
  output logic [15:0] distance,
  output logic [7:0]  fuel,
  output logic        fuel_empty,
  output logic        race_done,
  output logic        running
);

  localparam logic [10:0] RH   = 11'(ROAD_HEIGHT);
  localparam logic [2:0]  SLOW = 3'(SLOW_STEP);
  localparam logic [2:0]  FAST = 3'(FAST_STEP);
  localparam logic [7:0]  DD   = 8'(DIST_DIV);
  localparam logic [15:0] RL   = 16'(RACE_LEN);
  localparam logic [7:0]  FI   = 8'(FUEL_INIT);

  road_state_t state;
  logic [7:0]  acc;
  logic        finish_now;
  logic        restart;
  logic        frame;
  logic [2:0]  target;
  logic [10:0] off_sum;
  logic [10:0] off_wrap;
  logic [7:0]  acc_sum;

  assign finish_now = (state == ST_RUN) && (distance >= RL);
  assign restart    = (state == ST_FINISH) && start;
  assign frame      = (state == ST_RUN) && startOfFrame && !finish_now;

  assign target = fuel_empty ? 3'd0
                : speed_target(speed, SLOW, FAST);

  // Velocity is always below the road height, so one subtract wraps.
  assign off_sum  = {1'b0, scroll_offset} + {8'd0, velocity};
  assign off_wrap = (off_sum >= RH) ? off_sum - RH : off_sum;
  assign acc_sum  = acc + {5'd0, velocity};

  velocity_ramp u_ramp (
    .clk      (clk),
    .reset    (resetN),
    .clear    (finish_now || restart),
    .enable   (frame),
    .target   (target),
    .velocity (velocity)
  );

  always_ff @(posedge clk) begin
    if (resetN) begin
      state         <= ST_IDLE;
      scroll_offset <= 10'd0;
      distance      <= 16'd0;
      acc           <= 8'd0;
      race_done     <= 1'b0;
      running       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (finish_now) begin
            state     <= ST_FINISH;
            race_done <= 1'b1;
            running   <= 1'b0;
          end else if (startOfFrame) begin
            scroll_offset <= off_wrap[9:0];
            if (acc_sum >= DD) begin
              acc <= acc_sum - DD;
              if (distance != 16'hFFFF) begin
                distance <= distance + 16'd1;
              end
            end else begin
              acc <= acc_sum;
            end
          end
        end
        ST_FINISH: begin
          if (start) begin
            state         <= ST_RUN;
            race_done     <= 1'b0;
            running       <= 1'b1;
            scroll_offset <= 10'd0;
            distance      <= 16'd0;
            acc           <= 8'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROAD_FUEL_EN
  logic [7:0] burn;
  logic [7:0] fuel_nx;
  logic       load;

  assign load = refuel || restart || ((state == ST_IDLE) && start);

  always_comb begin
    burn = 8'd0;
    if (velocity == 3'd0) begin
      burn = 8'd0;
    end else if (velocity <= SLOW) begin
      burn = 8'd1;
    end else begin
      burn = 8'd2;
    end
  end

  always_comb begin
    fuel_nx = fuel;
    if (load) begin
      fuel_nx = FI;
    end else if ((state == ST_RUN) && one_sec) begin
      fuel_nx = (fuel > burn) ? fuel - burn : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      fuel       <= FI;
      fuel_empty <= 1'b0;
    end else begin
      fuel       <= fuel_nx;
      fuel_empty <= (fuel_nx == 8'd0);
    end
  end
`else
  logic unused_fuel_inputs;

  assign unused_fuel_inputs = ^{refuel, one_sec};
  assign fuel       = FI;
  assign fuel_empty = 1'b0;
`endif

endmodule

// File: tb/tb_road_scroll_engine.sv
// Directed bench for road_scroll_engine with hand-computed
// expectations; RACE_LEN is shortened so the finish is reachable.
module tb_road_scroll_engine;

  localparam int RL = 40;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        one_sec = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic        start = 1'b0;
  logic        refuel = 1'b0;
  logic [9:0]  scroll_offset;
  logic [2:0]  velocity;
  logic [15:0] distance;
  logic [7:0]  fuel;
  logic        fuel_empty;
  logic        race_done;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  road_scroll_engine #(.RACE_LEN(RL)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .one_sec       (one_sec),
    .speed         (speed),
    .start         (start),
    .refuel        (refuel),
    .scroll_offset (scroll_offset),
    .velocity      (velocity),
    .distance      (distance),
    .fuel          (fuel),
    .fuel_empty    (fuel_empty),
    .race_done     (race_done),
    .running       (running)
  );

  // Called at a falling edge; drives one rising edge, returns
  // at the next falling edge with pulses cleared.
  task automatic cyc(input logic sof, input logic st,
                     input logic one, input logic rf,
                     input logic rst);
    startOfFrame = sof;
    start        = st;
    one_sec      = one;
    refuel       = rf;
    resetN       = rst;
    @(negedge clk);
    startOfFrame = 1'b0;
    start        = 1'b0;
    one_sec      = 1'b0;
    refuel       = 1'b0;
    resetN       = 1'b0;
  endtask

  task automatic frame();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({scroll_offset, velocity, distance} !== 29'd0) begin
      n_bad++;
      $display("FAIL rst_regs got off=%0d v=%0d d=%0d want 0/0/0",
               scroll_offset, velocity, distance);
    end
    n_cmp++;
    if ({fuel, fuel_empty, race_done, running} !== {8'd100, 3'b000}) begin
      n_bad++;
      $display("FAIL rst_flags got fuel=%0d e=%b rd=%b run=%b want 100/0/0/0",
               fuel, fuel_empty, race_done, running);
    end
    speed = 2'd1;
    frame();
    n_cmp++;
    if (scroll_offset !== 10'd0 || running !== 1'b0 || velocity !== 3'd0) begin
      n_bad++;
      $display("FAIL idle_hold got off=%0d run=%b v=%0d want 0/0/0",
               scroll_offset, running, velocity);
    end
  endtask

  task automatic test_slow_ramp();
    int ev[4] = '{1, 2, 2, 2};
    int eo[4] = '{0, 1, 3, 5};
    speed = 2'd1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_bad++;
      $display("FAIL start_run got %b want 1", running);
    end
    for (int i = 0; i < 4; i++) begin
      frame();
      n_cmp++;
      if (velocity !== 3'(ev[i]) || scroll_offset !== 10'(eo[i])) begin
        n_bad++;
        $display("FAIL slow[%0d] got v=%0d off=%0d want v=%0d off=%0d",
                 i, velocity, scroll_offset, ev[i], eo[i]);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (running !== 1'b1 || scroll_offset !== 10'd5 || velocity !== 3'd2) begin
      n_bad++;
      $display("FAIL start_in_run got run=%b off=%0d v=%0d want 1/5/2",
               running, scroll_offset, velocity);
    end
  endtask

  task automatic test_fast_ramp();
    int ev[9] = '{3, 4, 5, 5, 4, 3, 2, 1, 0};
    int eo[9] = '{7, 10, 14, 19, 24, 28, 31, 33, 34};
    for (int i = 0; i < 9; i++) begin
      speed = (i < 4) ? 2'd2 : 2'd0;
      frame();
      n_cmp++;
      if (velocity !== 3'(ev[i]) || scroll_offset !== 10'(eo[i])) begin
        n_bad++;
        $display("FAIL fast[%0d] got v=%0d off=%0d want v=%0d off=%0d",
                 i, velocity, scroll_offset, ev[i], eo[i]);
      end
    end
    speed = 2'd3;
    frame();
    n_cmp++;
    if (velocity !== 3'd0 || scroll_offset !== 10'd34 || distance !== 16'd2) begin
      n_bad++;
      $display("FAIL code3_stop got v=%0d off=%0d d=%0d want 0/34/2",
               velocity, scroll_offset, distance);
    end
  endtask

  task automatic test_wrap();
    int over = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    speed = 2'd1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) frame();
    speed = 2'd2;
    for (int i = 0; i < 3; i++) frame();
    n_cmp++;
    if (scroll_offset !== 10'd18 || velocity !== 3'd5) begin
      n_bad++;
      $display("FAIL wrap_pre got off=%0d v=%0d want 18/5",
               scroll_offset, velocity);
    end
    for (int i = 0; i < 92; i++) begin
      frame();
      if (scroll_offset >= 10'd480) over++;
    end
    n_cmp++;
    if (scroll_offset !== 10'd478 || velocity !== 3'd5) begin
      n_bad++;
      $display("FAIL wrap_478 got off=%0d v=%0d want 478/5",
               scroll_offset, velocity);
    end
    frame();
    if (scroll_offset >= 10'd480) over++;
    n_cmp++;
    if (scroll_offset !== 10'd3) begin
      n_bad++;
      $display("FAIL wrap_3 got off=%0d want 3", scroll_offset);
    end
    n_cmp++;
    if (over !== 0 || distance !== 16'd30) begin
      n_bad++;
      $display("FAIL wrap_range got over=%0d d=%0d want 0/30",
               over, distance);
    end
  endtask

  task automatic test_finish();
    int k = 0;
    while (race_done !== 1'b1 && k < 200) begin
      frame();
      k++;
    end
    n_cmp++;
    if (race_done !== 1'b1) begin
      n_bad++;
      $display("FAIL finish_timeout got rd=%b want 1 within 200 frames",
               race_done);
    end
    n_cmp++;
    if (k !== 33 || running !== 1'b0 || velocity !== 3'd0) begin
      n_bad++;
      $display("FAIL finish_state got frames=%0d run=%b v=%0d want 33/0/0",
               k, running, velocity);
    end
    for (int i = 0; i < 3; i++) frame();
    n_cmp++;
    if (scroll_offset !== 10'd163 || distance !== 16'd40 || race_done !== 1'b1) begin
      n_bad++;
      $display("FAIL finish_frozen got off=%0d d=%0d rd=%b want 163/40/1",
               scroll_offset, distance, race_done);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (running !== 1'b1 || race_done !== 1'b0 || distance !== 16'd0 ||
        scroll_offset !== 10'd0 || velocity !== 3'd0) begin
      n_bad++;
      $display("FAIL restart got run=%b rd=%b d=%0d off=%0d v=%0d want 1/0/0/0/0",
               running, race_done, distance, scroll_offset, velocity);
    end
    frame();
    n_cmp++;
    if (velocity !== 3'd1 || scroll_offset !== 10'd0) begin
      n_bad++;
      $display("FAIL restart_frame got v=%0d off=%0d want 1/0",
               velocity, scroll_offset);
    end
  endtask

  task automatic test_fuel();
    int ev[5] = '{4, 3, 2, 1, 0};
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    speed = 2'd2;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) frame();
`ifdef ROAD_FUEL_EN
    for (int i = 0; i < 49; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (fuel !== 8'd2 || fuel_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL fuel_burn got fuel=%0d e=%b want 2/0",
               fuel, fuel_empty);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (fuel !== 8'd0 || fuel_empty !== 1'b1 ||
        velocity !== 3'd5 || scroll_offset !== 10'd15) begin
      n_bad++;
      $display("FAIL fuel_sof_sec got fuel=%0d e=%b v=%0d off=%0d want 0/1/5/15",
               fuel, fuel_empty, velocity, scroll_offset);
    end
    for (int i = 0; i < 5; i++) begin
      frame();
      n_cmp++;
      if (velocity !== 3'(ev[i])) begin
        n_bad++;
        $display("FAIL fuel_ramp[%0d] got v=%0d want %0d",
                 i, velocity, ev[i]);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (fuel !== 8'd100 || fuel_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL refuel got fuel=%0d e=%b want 100/0",
               fuel, fuel_empty);
    end
    frame();
    frame();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (velocity !== 3'd2 || fuel !== 8'd99) begin
      n_bad++;
      $display("FAIL fuel_slow got v=%0d fuel=%0d want 2/99",
               velocity, fuel);
    end
`else
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (fuel !== 8'd100 || fuel_empty !== 1'b0 ||
        velocity !== 3'd5 || scroll_offset !== 10'd15) begin
      n_bad++;
      $display("FAIL nofuel got fuel=%0d e=%b v=%0d off=%0d want 100/0/5/15",
               fuel, fuel_empty, velocity, scroll_offset);
    end
    for (int i = 0; i < 5; i++) begin
      speed = 2'd0;
      frame();
      n_cmp++;
      if (velocity !== 3'(ev[i])) begin
        n_bad++;
        $display("FAIL nofuel_ramp[%0d] got v=%0d want %0d",
                 i, velocity, ev[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    speed = 2'd2;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame();
    n_cmp++;
    if (velocity !== 3'd3 || scroll_offset !== 10'd3) begin
      n_bad++;
      $display("FAIL mid_pre got v=%0d off=%0d want 3/3",
               velocity, scroll_offset);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({scroll_offset, velocity, distance} !== 29'd0 ||
        {fuel, fuel_empty, race_done, running} !== {8'd100, 3'b000}) begin
      n_bad++;
      $display("FAIL mid_reset got off=%0d v=%0d d=%0d fuel=%0d run=%b want 0/0/0/100/0",
               scroll_offset, velocity, distance, fuel, running);
    end
    frame();
    n_cmp++;
    if (velocity !== 3'd0 || running !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_idle got v=%0d run=%b want 0/0",
               velocity, running);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_slow_ramp();
    test_fast_ramp();
    test_wrap();
    test_finish();
    test_fuel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
